// File: rtl/dcache_port_arbiter.sv
// dcache_port_arbiter: shares the D-cache port among NUM_LD loads and one store commit, routes in-order load responses.
// Define DCACHE_ARB_STATS_EN to add grant/stall counters on the stat_* ports; they are tied to 0 otherwise.
module dcache_port_arbiter #(
   parameter int NUM_LD       = 2,
   parameter int OUT_DEPTH    = 4,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic [NUM_LD-1:0]      ld_req,
   input  logic [NUM_LD-1:0][31:0] ld_addr,
   output logic [NUM_LD-1:0]      ld_grant,
   input  logic                   st_req,
   input  logic [31:0]            st_addr,
   input  logic [31:0]            st_data,
   output logic                   st_grant,
   input  logic                   flush,
   output logic                   mem_req_valid,
   output logic                   mem_req_is_store,
   output logic [31:0]            mem_req_addr,
   output logic [31:0]            mem_req_data,
   input  logic                   mem_req_ready,
   input  logic                   mem_rsp_valid,
   input  logic [63:0]            mem_rsp_data,
   output logic [NUM_LD-1:0]      ld_rsp_valid,
   output logic [63:0]            ld_rsp_data,
   output logic                   rsp_err,
   output logic [31:0]            stat_ld_grants,
   output logic [31:0]            stat_st_grants,
   output logic [31:0]            stat_full_stalls
);
   localparam int IDW = NUM_LD > 1 ? $clog2(NUM_LD) : 1;
   localparam int PW  = $clog2(OUT_DEPTH);
   localparam int SW  = $clog2(STARVE_LIMIT + 1);
   logic [IDW-1:0]       rr_ptr, ld_sel;
   logic [SW-1:0]        starve_cnt;
   logic [PW-1:0]        wr_ptr, rd_ptr;
   logic [PW:0]          cnt;
   logic [OUT_DEPTH-1:0] live;
   logic [IDW-1:0]       fifo_id [OUT_DEPTH];
   logic [NUM_LD-1:0]    ld_elig;
   logic full, can_issue, any_ld, ld_win, st_win, pop, deliver;
   assign full      = cnt == (PW+1)'(OUT_DEPTH);
   assign can_issue = reset_n && mem_req_ready && !flush;
   assign ld_elig   = full ? '0 : ld_req;
   assign any_ld    = |ld_elig;
   // Descending scan: the last hit is the first eligible requester at or after rr_ptr.
   always_comb begin
      ld_sel = rr_ptr;
      for (int k = NUM_LD - 1; k >= 0; k--)
         if (ld_elig[(int'(rr_ptr) + k) % NUM_LD]) ld_sel = IDW'((int'(rr_ptr) + k) % NUM_LD);
   end
   assign st_win           = can_issue && st_req && (starve_cnt == SW'(STARVE_LIMIT) || !any_ld);
   assign ld_win           = can_issue && any_ld && !st_win;
   assign ld_grant         = ld_win ? NUM_LD'(1) << ld_sel : '0;
   assign st_grant         = st_win;
   assign mem_req_valid    = ld_win || st_win;
   assign mem_req_is_store = st_win;
   assign mem_req_addr     = st_win ? st_addr : ld_win ? ld_addr[ld_sel] : '0;
   assign mem_req_data     = st_win ? st_data : '0;
   assign pop              = reset_n && mem_rsp_valid && cnt != '0;
   assign deliver          = pop && live[rd_ptr];
   assign ld_rsp_valid     = deliver ? NUM_LD'(1) << fifo_id[rd_ptr] : '0;
   assign ld_rsp_data      = deliver ? mem_rsp_data : '0;
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         rr_ptr     <= '0;
         starve_cnt <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         cnt        <= '0;
         live       <= '0;
         rsp_err    <= 1'b0;
      end else begin
         if (ld_win) rr_ptr <= ld_sel == IDW'(NUM_LD - 1) ? '0 : ld_sel + 1'b1;
         if (st_win) starve_cnt <= '0;
         else if (st_req && mem_req_ready && starve_cnt != SW'(STARVE_LIMIT)) starve_cnt <= starve_cnt + 1'b1;
         if (ld_win) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         cnt  <= cnt + (PW+1)'(ld_win) - (PW+1)'(pop);
         live <= (flush ? '0 : live) | (ld_win ? OUT_DEPTH'(1) << wr_ptr : '0);
         if (mem_rsp_valid && cnt == '0) rsp_err <= 1'b1;
      end
   end
   always_ff @(posedge clock)
      if (ld_win) fifo_id[wr_ptr] <= ld_sel;
`ifdef DCACHE_ARB_STATS_EN
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         stat_ld_grants   <= '0;
         stat_st_grants   <= '0;
         stat_full_stalls <= '0;
      end else begin
         stat_ld_grants   <= stat_ld_grants + 32'(ld_win);
         stat_st_grants   <= stat_st_grants + 32'(st_win);
         stat_full_stalls <= stat_full_stalls + 32'(full && |ld_req);
      end
   end
`else
   assign stat_ld_grants   = '0;
   assign stat_st_grants   = '0;
   assign stat_full_stalls = '0;
`endif
endmodule

// File: tb/tb_dcache_port_arbiter.sv
// tb_dcache_port_arbiter: directed and random stimulus checked against a queue-based reference model.
module tb_dcache_port_arbiter;
   localparam int NL = 2, DEPTH = 4, LIM = 4;
   logic clock = 0, reset_n = 0;
   logic [1:0] ld_req = 0, ld_grant, ld_rsp_valid;
   logic [1:0][31:0] ld_addr = '0;
   logic st_req = 0, st_grant, flush = 0, ready = 0, rsp_valid = 0, req_valid, is_store, rsp_err;
   logic [31:0] st_addr = 0, st_data = 0, req_addr, req_data, s_ld, s_st, s_fs;
   logic [63:0] rsp_data = 0, ld_rsp_data;
   always #5 clock = ~clock;

   dcache_port_arbiter #(.NUM_LD(NL), .OUT_DEPTH(DEPTH), .STARVE_LIMIT(LIM)) dut (
      .clock(clock), .reset_n(reset_n), .ld_req(ld_req), .ld_addr(ld_addr), .ld_grant(ld_grant),
      .st_req(st_req), .st_addr(st_addr), .st_data(st_data), .st_grant(st_grant), .flush(flush),
      .mem_req_valid(req_valid), .mem_req_is_store(is_store), .mem_req_addr(req_addr),
      .mem_req_data(req_data), .mem_req_ready(ready), .mem_rsp_valid(rsp_valid),
      .mem_rsp_data(rsp_data), .ld_rsp_valid(ld_rsp_valid), .ld_rsp_data(ld_rsp_data),
      .rsp_err(rsp_err), .stat_ld_grants(s_ld), .stat_st_grants(s_st), .stat_full_stalls(s_fs));

   typedef struct {int id; bit live;} ent_t;
   ent_t mq[$];
   int rr = 0, starve = 0, errs = 0, checks = 0;
   bit merr = 0;
   logic [31:0] m_ld = 0, m_st = 0, m_fs = 0;
   logic [1:0] obs_ldg, obs_rv;
   logic obs_stg, obs_err;
   logic [31:0] obs_addr;
   logic [63:0] obs_rd;

   task automatic chk(string tag, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic cycle();
      int win;
      bit full, ok, sw, lw;
      logic [1:0] e_ldg, e_rv;
      logic [63:0] e_rd;
      @(negedge clock);
      full = mq.size() == DEPTH;
      ok = reset_n && ready && !flush;
      win = -1;
      for (int k = 0; k < NL; k++)
         if (win < 0 && !full && ld_req[(rr + k) % NL]) win = (rr + k) % NL;
      sw = ok && st_req && (starve == LIM || win < 0);
      lw = ok && win >= 0 && !sw;
      e_ldg = lw ? 2'(1 << win) : 2'b0;
      e_rv = 0;
      e_rd = 0;
      if (reset_n && rsp_valid && mq.size() > 0 && mq[0].live) begin
         e_rv = 2'(1 << mq[0].id);
         e_rd = rsp_data;
      end
      {obs_ldg, obs_stg, obs_rv, obs_rd, obs_err, obs_addr} = {ld_grant, st_grant, ld_rsp_valid, ld_rsp_data, rsp_err, req_addr};
      chk("ld_grant", ld_grant, e_ldg);
      chk("st_grant", st_grant, sw);
      chk("req_valid", req_valid, sw || lw);
      chk("is_store", is_store, sw);
      chk("req_addr", req_addr, sw ? st_addr : lw ? ld_addr[win] : 0);
      chk("req_data", req_data, sw ? st_data : 0);
      chk("rsp_valid", ld_rsp_valid, e_rv);
      chk("rsp_data", ld_rsp_data, e_rd);
      chk("rsp_err", rsp_err, merr);
`ifdef DCACHE_ARB_STATS_EN
      chk("stat_ld", s_ld, m_ld);
      chk("stat_st", s_st, m_st);
      chk("stat_fs", s_fs, m_fs);
`else
      chk("stat_tied", {s_ld, s_st, s_fs}, 0);
`endif
      if (!reset_n) begin
         mq.delete();
         {rr, starve, merr, m_ld, m_st, m_fs} = 0;
      end else begin
         m_ld += 32'(lw);
         m_st += 32'(sw);
         m_fs += 32'(full && ld_req != 0);
         if (lw) rr = (win + 1) % NL;
         if (sw) starve = 0;
         else if (st_req && ready && starve < LIM) starve++;
         if (rsp_valid && mq.size() == 0) merr = 1;
         else if (rsp_valid) void'(mq.pop_front());
         if (flush) foreach (mq[i]) mq[i].live = 0;
         if (lw) mq.push_back('{win, 1'b1});
      end
      @(posedge clock);
      #1;
   endtask

   task automatic idle_in();
      {ld_req, st_req, flush, rsp_valid} = 0;
      ready = 1;
   endtask

   task automatic drain();
      for (int i = 0; i < 8 && mq.size() > 0; i++) begin
         idle_in();
         rsp_valid = 1;
         rsp_data = {$urandom, $urandom};
         cycle();
      end
      idle_in();
   endtask

   initial begin
      idle_in();
      reset_n = 0;
      repeat (2) cycle();
      reset_n = 1;
      // round robin
      ld_req = 2'b11;
      ld_addr[0] = 32'h1000;
      ld_addr[1] = 32'h2000;
      for (int i = 0; i < 4; i++) begin
         cycle();
         chk("rr_grant", obs_ldg, (i % 2) ? 2'b10 : 2'b01);
         chk("rr_addr", obs_addr, (i % 2) ? 32'h2000 : 32'h1000);
      end
      drain();
      // starvation
      ld_req = 2'b11;
      st_req = 1;
      st_addr = 32'h3000;
      st_data = 32'hdead;
      for (int i = 1; i <= 6; i++) begin
         rsp_valid = mq.size() > 0;
         rsp_data = 64'(i);
         cycle();
         chk("starve_st", obs_stg, i == 5);
      end
      drain();
      // full FIFO
      ld_req = 2'b01;
      for (int i = 0; i < 4; i++) begin
         cycle();
         chk("fill_grant", obs_ldg, 2'b01);
      end
      st_req = 1;
      cycle();
      chk("full_ld", obs_ldg, 0);
      chk("full_st", obs_stg, 1);
      drain();
      // routing
      ld_req = 2'b10;
      cycle();
      ld_req = 2'b01;
      cycle();
      ld_req = 0;
      rsp_valid = 1;
      rsp_data = 64'hA;
      cycle();
      chk("route1_v", obs_rv, 2'b10);
      chk("route1_d", obs_rd, 64'hA);
      rsp_data = 64'hB;
      cycle();
      chk("route2_v", obs_rv, 2'b01);
      chk("route2_d", obs_rd, 64'hB);
      // flush
      idle_in();
      ld_req = 2'b01;
      repeat (2) cycle();
      ld_req = 0;
      flush = 1;
      cycle();
      flush = 0;
      rsp_valid = 1;
      repeat (2) begin
         cycle();
         chk("flush_drop", obs_rv, 0);
      end
      rsp_valid = 0;
      ld_req = 2'b01;
      cycle();
      ld_req = 0;
      rsp_valid = 1;
      rsp_data = 64'hC;
      cycle();
      chk("post_flush_v", obs_rv, 2'b01);
      chk("post_flush_d", obs_rd, 64'hC);
      // reset mid-operation
      idle_in();
      rsp_valid = 1;
      cycle();
      rsp_valid = 0;
      ld_req = 2'b11;
      repeat (3) cycle();
      ld_req = 0;
      cycle();
      chk("err_set", obs_err, 1);
      reset_n = 0;
      ld_req = 2'b11;
      st_req = 1;
      rsp_valid = 1;
      cycle();
      chk("rst_grants", {obs_ldg, obs_stg, obs_rv}, 0);
      reset_n = 1;
      idle_in();
      cycle();
      chk("rst_err_clr", obs_err, 0);
      rsp_valid = 1;
      cycle();
      rsp_valid = 0;
      cycle();
      chk("err_reset", obs_err, 1);
      // random
      for (int i = 0; i < 500; i++) begin
         reset_n = $urandom_range(0, 99) >= 2;
         ld_req = 2'($urandom);
         ld_addr[0] = $urandom;
         ld_addr[1] = $urandom;
         st_req = $urandom_range(0, 2) == 0;
         st_addr = $urandom;
         st_data = $urandom;
         flush = $urandom_range(0, 19) == 0;
         ready = $urandom_range(0, 4) != 0;
         rsp_valid = $urandom_range(0, 9) < 4;
         rsp_data = {$urandom, $urandom};
         cycle();
      end
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
